// File: rtl/ex_mem_stage.sv
// Execute->memory pipeline boundary.
// Selects the result, resolves branches and jumps, issues a one-cycle PC
// redirect, and buffers beats in a main + skid pair toward the memory stage.
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
  input  logic                  ex_alu_zero_i,
  input  logic [DATA_WIDTH-1:0] ex_store_data_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] ex_target_i,
  input  logic [RD_WIDTH-1:0]   ex_rd_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic                  ex_branch_i,
  input  logic                  ex_br_on_zero_i,
  input  logic                  ex_jump_i,
  input  logic                  ex_link_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [DATA_WIDTH-1:0] mem_result_o,
  output logic [DATA_WIDTH-1:0] mem_store_data_o,
  output logic [RD_WIDTH-1:0]   mem_rd_o,
  output logic                  mem_reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  fwd_valid_o,
  output logic [RD_WIDTH-1:0]   fwd_rd_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o
);

  typedef enum logic {RUN, REDIR} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [RD_WIDTH-1:0]   rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } entry_t;

  state_t state, state_nx;
  entry_t main_q, skid_q, beat;
  logic   main_valid, skid_valid;
  logic   accept, keep, drain, taken;

  // Beats accepted during REDIR are wrong-path and never enter the buffer.
  assign ex_ready_o = (state == REDIR) | ~skid_valid;
  assign accept     = ex_valid_i & ex_ready_o;
  assign keep       = accept & (state == RUN);
  assign drain      = main_valid & mem_ready_i;
  assign taken      = ex_jump_i | (ex_branch_i & (ex_alu_zero_i == ex_br_on_zero_i));

  // Pack the incoming beat with the selected result.
  always_comb begin
    beat            = '0;
    beat.result     = ex_link_i ? ex_pc_plus4_i : ex_alu_result_i;
    beat.store_data = ex_store_data_i;
    beat.rd         = ex_rd_i;
    beat.reg_write  = ex_reg_write_i;
    beat.mem_read   = ex_mem_read_i;
    beat.mem_write  = ex_mem_write_i;
  end

  // Main/skid buffer; flush dominates accept and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain && skid_valid) begin
      // ex_ready_o is low in RUN while skid is full, so no beat competes here.
      main_q     <= skid_q;
      main_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (keep && (!main_valid || drain)) begin
      main_q     <= beat;
      main_valid <= 1'b1;
    end else if (keep) begin
      skid_q     <= beat;
      skid_valid <= 1'b1;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  // State register and redirect target capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      redirect_pc_o <= '0;
    end else begin
      state <= state_nx;
      if (!flush_i && keep && taken)
        redirect_pc_o <= {ex_target_i[DATA_WIDTH-1:1], 1'b0};
    end
  end

  // Next-state: one REDIR cycle per accepted taken beat unless flushed.
  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = RUN;
    end else begin
      case (state)
        RUN:     if (keep && taken) state_nx = REDIR;
        REDIR:   state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  assign redirect_o       = (state == REDIR);
  assign mem_valid_o      = main_valid;
  assign mem_result_o     = main_q.result;
  assign mem_store_data_o = main_q.store_data;
  assign mem_rd_o         = main_q.rd;
  assign mem_reg_write_o  = main_q.reg_write;
  assign mem_read_o       = main_q.mem_read;
  assign mem_write_o      = main_q.mem_write;
  assign fwd_valid_o      = main_valid & main_q.reg_write & (main_q.rd != '0) & ~main_q.mem_read;
  assign fwd_rd_o         = main_q.rd;
  assign fwd_data_o       = main_q.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, ex_valid_i, ex_ready_o;
  logic [31:0] ex_alu_result_i, ex_store_data_i, ex_pc_plus4_i, ex_target_i;
  logic        ex_alu_zero_i;
  logic [4:0]  ex_rd_i;
  logic        ex_reg_write_i, ex_mem_read_i, ex_mem_write_i;
  logic        ex_branch_i, ex_br_on_zero_i, ex_jump_i, ex_link_i;
  logic        mem_valid_o, mem_ready_i;
  logic [31:0] mem_result_o, mem_store_data_o;
  logic [4:0]  mem_rd_o;
  logic        mem_reg_write_o, mem_read_o, mem_write_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_result_i(ex_alu_result_i), .ex_alu_zero_i(ex_alu_zero_i),
    .ex_store_data_i(ex_store_data_i), .ex_pc_plus4_i(ex_pc_plus4_i),
    .ex_target_i(ex_target_i), .ex_rd_i(ex_rd_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_mem_write_i(ex_mem_write_i), .ex_branch_i(ex_branch_i),
    .ex_br_on_zero_i(ex_br_on_zero_i), .ex_jump_i(ex_jump_i), .ex_link_i(ex_link_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_result_o(mem_result_o), .mem_store_data_o(mem_store_data_o),
    .mem_rd_o(mem_rd_o), .mem_reg_write_o(mem_reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Plain ALU beat writing rd; control-flow flags cleared.
  task automatic alu_beat(input logic [31:0] res, input logic [4:0] rd);
    ex_valid_i      = 1'b1;
    ex_alu_result_i = res;
    ex_store_data_i = ~res;
    ex_pc_plus4_i   = 32'h0;
    ex_target_i     = 32'h0;
    ex_alu_zero_i   = 1'b0;
    ex_rd_i         = rd;
    ex_reg_write_i  = 1'b1;
    ex_mem_read_i   = 1'b0;
    ex_mem_write_i  = 1'b0;
    ex_branch_i     = 1'b0;
    ex_br_on_zero_i = 1'b0;
    ex_jump_i       = 1'b0;
    ex_link_i       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
    alu_beat(32'h0, 5'd0);
    ex_valid_i = 1'b0;
    #12;
    check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    check("rst_redirect", 32'(redirect_o), 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    check("rst_result", mem_result_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1. single beat
    mem_ready_i = 1'b1;
    alu_beat(32'h0000_1234, 5'd5);
    step();
    ex_valid_i = 1'b0;
    check("t1_valid", 32'(mem_valid_o), 32'd1);
    check("t1_result", mem_result_o, 32'h0000_1234);
    check("t1_store", mem_store_data_o, 32'hFFFF_EDCB);
    check("t1_rd", 32'(mem_rd_o), 32'd5);
    check("t1_fwd_valid", 32'(fwd_valid_o), 32'd1);
    check("t1_fwd_data", fwd_data_o, 32'h0000_1234);
    step();
    check("t1_drained", 32'(mem_valid_o), 32'd0);

    // 2. backpressure A,B,C
    mem_ready_i = 1'b0;
    alu_beat(32'hA, 5'd1); step();
    alu_beat(32'hB, 5'd2); step();
    check("t2_ready_low", 32'(ex_ready_o), 32'd0);
    alu_beat(32'hC, 5'd3); step();
    check("t2_hold_A", mem_result_o, 32'hA);
    check("t2_still_stalled", 32'(ex_ready_o), 32'd0);
    mem_ready_i = 1'b1; step();
    check("t2_B", mem_result_o, 32'hB);
    check("t2_B_rd", 32'(mem_rd_o), 32'd2);
    check("t2_ready_back", 32'(ex_ready_o), 32'd1);
    step();
    ex_valid_i = 1'b0;
    check("t2_C", mem_result_o, 32'hC);
    check("t2_C_valid", 32'(mem_valid_o), 32'd1);
    step();
    check("t2_empty", 32'(mem_valid_o), 32'd0);

    // 3. BEQ taken, next beat dropped
    alu_beat(32'h0, 5'd0);
    ex_reg_write_i = 1'b0; ex_branch_i = 1'b1; ex_br_on_zero_i = 1'b1;
    ex_alu_zero_i = 1'b1; ex_target_i = 32'h0000_0081;
    step();
    check("t3_redirect", 32'(redirect_o), 32'd1);
    check("t3_redirect_pc", redirect_pc_o, 32'h0000_0080);
    check("t3_br_buffered", 32'(mem_valid_o), 32'd1);
    check("t3_br_no_write", 32'(mem_reg_write_o), 32'd0);
    check("t3_ready_redir", 32'(ex_ready_o), 32'd1);
    alu_beat(32'hDEAD, 5'd7);
    step();
    ex_valid_i = 1'b0;
    check("t3_pulse_end", 32'(redirect_o), 32'd0);
    check("t3_dropped", 32'(mem_valid_o), 32'd0);
    check("t3_pc_hold", redirect_pc_o, 32'h0000_0080);

    // 4. BNE not taken, then JAL with link
    alu_beat(32'h0, 5'd0);
    ex_reg_write_i = 1'b0; ex_branch_i = 1'b1; ex_br_on_zero_i = 1'b0;
    ex_alu_zero_i = 1'b1; ex_target_i = 32'h0000_0500;
    step();
    check("t4_bne_no_redir", 32'(redirect_o), 32'd0);
    check("t4_bne_valid", 32'(mem_valid_o), 32'd1);
    alu_beat(32'h999, 5'd1);
    ex_jump_i = 1'b1; ex_link_i = 1'b1; ex_pc_plus4_i = 32'h104; ex_target_i = 32'h200;
    step();
    ex_valid_i = 1'b0;
    check("t4_link_result", mem_result_o, 32'h104);
    check("t4_jal_redirect", 32'(redirect_o), 32'd1);
    check("t4_jal_pc", redirect_pc_o, 32'h200);
    step();
    check("t4_redir_one_cycle", 32'(redirect_o), 32'd0);

    // 5. flush with main+skid full and taken beat presented
    mem_ready_i = 1'b0;
    alu_beat(32'h11, 5'd1); step();
    alu_beat(32'h22, 5'd2); step();
    alu_beat(32'h33, 5'd3); ex_jump_i = 1'b1; ex_target_i = 32'h300;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; ex_valid_i = 1'b0;
    check("t5_flushed", 32'(mem_valid_o), 32'd0);
    check("t5_no_redirect", 32'(redirect_o), 32'd0);
    check("t5_ready", 32'(ex_ready_o), 32'd1);
    // taken beat actually accepted during flush: still no redirect
    alu_beat(32'h44, 5'd4); ex_jump_i = 1'b1; ex_target_i = 32'h400;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; ex_valid_i = 1'b0;
    check("t5_acc_flush_noredir", 32'(redirect_o), 32'd0);
    check("t5_acc_flush_empty", 32'(mem_valid_o), 32'd0);

    // 6. async reset mid-stall, then load rd=0
    alu_beat(32'h55, 5'd5); step();
    alu_beat(32'h66, 5'd6); step();
    check("t6_skid_full", 32'(ex_ready_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(mem_valid_o), 32'd0);
    check("t6_rst_ready", 32'(ex_ready_o), 32'd1);
    check("t6_rst_result", mem_result_o, 32'h0);
    check("t6_rst_fwd", 32'(fwd_valid_o), 32'd0);
    step();
    rst_n = 1'b1;
    mem_ready_i = 1'b1;
    alu_beat(32'h1000, 5'd0); ex_mem_read_i = 1'b1;
    step();
    check("t6_load_valid", 32'(mem_valid_o), 32'd1);
    check("t6_load_read", 32'(mem_read_o), 32'd1);
    check("t6_load_rd0_fwd", 32'(fwd_valid_o), 32'd0);
    alu_beat(32'h2000, 5'd3); ex_mem_read_i = 1'b1;
    step();
    check("t6_load_rd3_fwd", 32'(fwd_valid_o), 32'd0);
    alu_beat(32'h3000, 5'd3); ex_mem_write_i = 1'b1; ex_reg_write_i = 1'b0;
    step();
    ex_valid_i = 1'b0;
    check("t6_store_write", 32'(mem_write_o), 32'd1);
    check("t6_store_fwd", 32'(fwd_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
